// File: rtl/cu_pkg.sv
// Shared types and encodings for the multicycle control unit.
package cu_pkg;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_ERROR
    } state_t;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_WR3   = 4'b0001;
    localparam logic [3:0] OP_OUT   = 4'b0010;
    localparam logic [3:0] OP_SEL12 = 4'b0011;
    localparam logic [3:0] OP_IMM0  = 4'b0100;
    localparam logic [3:0] OP_IMM2  = 4'b0101;
    localparam logic [3:0] OP_IMM3  = 4'b0110;
    localparam logic [3:0] OP_LOAD  = 4'b0111;
    localparam logic [3:0] OP_STORE = 4'b1000;
    localparam logic [3:0] OP_SEL19 = 4'b1001;
    localparam logic [3:0] OP_SEL1  = 4'b1010;
    localparam logic [3:0] OP_SEL2  = 4'b1011;
    localparam logic [3:0] OP_SEL25 = 4'b1100;
    localparam logic [3:0] OP_NOP   = 4'b1110;
    localparam logic [3:0] OP_SEL3  = 4'b1111;

    localparam logic [2:0] ALU_OP0 = 3'b000;
    localparam logic [2:0] ALU_OP1 = 3'b001;
    localparam logic [2:0] ALU_OP2 = 3'b010;
    localparam logic [2:0] ALU_OP3 = 3'b011;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/cu_decode.sv
// Combinational instruction decode: latched opcode/funct to datapath selects,
// ALU operation and instruction-class flags. sel[i] drives datapath select S(i+1).
module cu_decode
    import cu_pkg::*;
#(
    parameter int OPW  = 4,
    parameter int FNW  = 3,
    parameter int ALUW = 3,
    parameter int NSEL = 9
) (
    input  logic [OPW-1:0]  opcode,
    input  logic [FNW-1:0]  funct,
    output logic [NSEL-1:0] sel,
    output logic [ALUW-1:0] alu_op,
    output logic            legal,
    output logic            is_write,
    output logic            is_load,
    output logic            is_store,
    output logic            is_outld
);

    logic [8:0] sel9;

    always_comb begin
        sel9     = '0;
        alu_op   = ALUW'(ALU_OP0);
        legal    = 1'b1;
        is_write = 1'b0;
        is_load  = 1'b0;
        is_store = 1'b0;
        is_outld = 1'b0;
        case (4'(opcode))
            OP_RTYPE: begin
                alu_op   = ALUW'(funct);
                sel9     = 9'b001001000;
                is_write = 1'b1;
            end
            OP_IMM0, OP_IMM2, OP_IMM3: begin
                sel9     = 9'b011000000;
                is_write = 1'b1;
                if (4'(opcode) == OP_IMM2) alu_op = ALUW'(ALU_OP2);
                if (4'(opcode) == OP_IMM3) alu_op = ALUW'(ALU_OP3);
            end
            OP_LOAD: begin
                sel9    = 9'b010000000;
                is_load = 1'b1;
            end
            OP_STORE: begin
                sel9     = 9'b010000000;
                is_store = 1'b1;
            end
            OP_SEL2:  sel9 = 9'b000000010;
            OP_SEL25: begin
                sel9     = 9'b000010010;
                is_write = 1'b1;
            end
            OP_SEL12: sel9 = 9'b000000011;
            OP_SEL19: begin
                sel9   = 9'b100000001;
                alu_op = ALUW'(ALU_OP1);
            end
            OP_SEL1: begin
                sel9   = 9'b000000001;
                alu_op = ALUW'(ALU_OP1);
            end
            OP_WR3: begin
                sel9     = 9'b001101000;
                is_write = 1'b1;
            end
            OP_OUT:   is_outld = 1'b1;
            OP_NOP:   ;
            OP_SEL3:  sel9 = 9'b000000100;
            default:  legal = 1'b0;
        endcase
        sel = NSEL'(sel9);
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle controller: instruction handshake, decode-driven sequencing,
// data-memory wait with timeout, and a sticky error state.
//
// state    | meaning
// ST_FETCH | instr_ready high, waiting for an instruction handshake
// ST_EXEC  | decoded selects applied; last cycle for simple instructions
// ST_MEM   | memory access in flight, strobe held until mem_ack or timeout
// ST_WB    | register write-back, we and pc_en for one cycle
// ST_ERROR | sticky fault, only err_clr leaves
module multicycle_control_unit
    import cu_pkg::*;
#(
    parameter int OPW    = 4,
    parameter int FNW    = 3,
    parameter int ALUW   = 3,
    parameter int NSEL   = 9,
    parameter int MEM_TO = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [OPW-1:0]  opcode,
    input  logic [FNW-1:0]  funct,
    input  logic            mem_ack,
    input  logic            err_clr,
    output logic [ALUW-1:0] alu_op,
    output logic [NSEL-1:0] sel,
    output logic            we,
    output logic            mwe,
    output logic            mre,
    output logic            outld,
    output logic            pc_en,
    output logic [1:0]      err
);

    localparam int CW = $clog2(MEM_TO + 1);

    state_t          state_q, state_d;
    logic [OPW-1:0]  op_q, op_d;
    logic [FNW-1:0]  fn_q, fn_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      err_q, err_d;

    logic [NSEL-1:0] dec_sel;
    logic [ALUW-1:0] dec_alu;
    logic            dec_legal, dec_write, dec_load, dec_store, dec_outld;

    cu_decode #(.OPW(OPW), .FNW(FNW), .ALUW(ALUW), .NSEL(NSEL)) u_decode (
        .opcode   (op_q),
        .funct    (fn_q),
        .sel      (dec_sel),
        .alu_op   (dec_alu),
        .legal    (dec_legal),
        .is_write (dec_write),
        .is_load  (dec_load),
        .is_store (dec_store),
        .is_outld (dec_outld)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            op_q    <= '0;
            fn_q    <= '0;
            cnt_q   <= '0;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            fn_q    <= fn_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        fn_d        = fn_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        instr_ready = 1'b0;
        sel         = '0;
        alu_op      = '0;
        we          = 1'b0;
        mwe         = 1'b0;
        mre         = 1'b0;
        outld       = 1'b0;
        pc_en       = 1'b0;
        case (state_q)
            ST_FETCH: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    op_d    = opcode;
                    fn_d    = funct;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                sel    = dec_sel;
                alu_op = dec_alu;
                if (!dec_legal) begin
                    err_d   = ERR_ILLEGAL;
                    state_d = ST_ERROR;
                end else if (dec_load || dec_store) begin
                    cnt_d   = CW'(MEM_TO - 1);
                    state_d = ST_MEM;
                end else if (dec_write) begin
                    state_d = ST_WB;
                end else begin
                    pc_en   = 1'b1;
                    outld   = dec_outld;
                    state_d = ST_FETCH;
                end
            end
            ST_MEM: begin
                sel    = dec_sel;
                alu_op = dec_alu;
                mre    = dec_load;
                mwe    = dec_store;
                if (mem_ack) begin
                    pc_en   = dec_store;
                    state_d = dec_store ? ST_FETCH : ST_WB;
                end else if (cnt_q == '0) begin
                    // this was the last permitted no-ack cycle
                    err_d   = ERR_TIMEOUT;
                    state_d = ST_ERROR;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_WB: begin
                sel     = dec_sel;
                alu_op  = dec_alu;
                we      = 1'b1;
                pc_en   = 1'b1;
                state_d = ST_FETCH;
            end
            ST_ERROR: begin
                if (err_clr) begin
                    err_d   = ERR_NONE;
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_FETCH;
        endcase
    end

    assign err = err_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed self-checking bench for multicycle_control_unit.
module tb_multicycle_control_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [3:0] opcode = '0;
    logic [2:0] funct = '0;
    logic       mem_ack = 1'b0;
    logic       err_clr = 1'b0;
    logic [2:0] alu_op;
    logic [8:0] sel;
    logic       we, mwe, mre, outld, pc_en;
    logic [1:0] err;

    int errors = 0;
    int checks = 0;

    multicycle_control_unit dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .opcode(opcode), .funct(funct), .mem_ack(mem_ack), .err_clr(err_clr),
        .alu_op(alu_op), .sel(sel), .we(we), .mwe(mwe), .mre(mre), .outld(outld),
        .pc_en(pc_en), .err(err)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        @(negedge clk); #1;
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", instr_ready); end
        checks++; if ({we, mwe, mre, outld, pc_en} !== 5'b0) begin errors++; $display("FAIL reset_strobes got=%b exp=00000", {we, mwe, mre, outld, pc_en}); end
        checks++; if ({sel, alu_op, err} !== 14'b0) begin errors++; $display("FAIL reset_sel_alu_err got=%h exp=0", {sel, alu_op, err}); end
        rst_n = 1'b1;
    endtask

    task automatic test_rtype();
        @(negedge clk); instr_valid = 1'b1; opcode = 4'b0000; funct = 3'b101; #1;
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL rtype_ready got=%b exp=1", instr_ready); end
        @(negedge clk); instr_valid = 1'b0; opcode = 4'hF; funct = 3'b000; #1;
        checks++; if (alu_op !== 3'b101 || sel !== 9'h048) begin errors++; $display("FAIL rtype_exec alu=%b sel=%h exp alu=101 sel=048", alu_op, sel); end
        checks++; if ({we, pc_en, instr_ready} !== 3'b000) begin errors++; $display("FAIL rtype_exec_strobes got=%b exp=000", {we, pc_en, instr_ready}); end
        @(negedge clk); #1;
        checks++; if ({we, pc_en} !== 2'b11 || alu_op !== 3'b101 || sel !== 9'h048) begin errors++; $display("FAIL rtype_wb we_pc=%b alu=%b sel=%h exp 11/101/048", {we, pc_en}, alu_op, sel); end
        @(negedge clk); #1;
        checks++; if (instr_ready !== 1'b1 || {we, pc_en} !== 2'b00 || sel !== 9'h0) begin errors++; $display("FAIL rtype_fetch ready=%b we_pc=%b sel=%h exp 1/00/000", instr_ready, {we, pc_en}, sel); end
    endtask

    task automatic test_decode_table();
        logic [3:0] ops  [8] = '{4'h1, 4'h3, 4'h5, 4'h6, 4'hA, 4'hB, 4'hC, 4'hE};
        logic [8:0] sels [8] = '{9'h068, 9'h003, 9'h0C0, 9'h0C0, 9'h001, 9'h002, 9'h012, 9'h000};
        logic [2:0] alus [8] = '{3'd0, 3'd0, 3'd2, 3'd3, 3'd1, 3'd0, 3'd0, 3'd0};
        logic       wrs  [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); instr_valid = 1'b1; opcode = ops[i]; funct = 3'b111;
            @(negedge clk); instr_valid = 1'b0; #1;
            checks++; if (sel !== sels[i] || alu_op !== alus[i] || pc_en !== !wrs[i] || we !== 1'b0 || outld !== 1'b0)
                begin errors++; $display("FAIL decode_exec op=%b sel=%h alu=%b pc=%b we=%b exp sel=%h alu=%b pc=%b we=0", ops[i], sel, alu_op, pc_en, we, sels[i], alus[i], !wrs[i]); end
            if (wrs[i]) begin
                @(negedge clk); #1;
                checks++; if ({we, pc_en} !== 2'b11 || sel !== sels[i]) begin errors++; $display("FAIL decode_wb op=%b we_pc=%b sel=%h exp 11/%h", ops[i], {we, pc_en}, sel, sels[i]); end
            end
            @(negedge clk); #1;
            checks++; if (instr_ready !== 1'b1 || pc_en !== 1'b0) begin errors++; $display("FAIL decode_fetch op=%b ready=%b pc=%b exp 1/0", ops[i], instr_ready, pc_en); end
        end
    endtask

    task automatic test_load();
        int mre_cycles = 0;
        @(negedge clk); instr_valid = 1'b1; opcode = 4'b0111; funct = 3'b000;
        @(negedge clk); instr_valid = 1'b0; mem_ack = 1'b1; #1;
        checks++; if (sel !== 9'h080 || mre !== 1'b0 || pc_en !== 1'b0) begin errors++; $display("FAIL load_exec sel=%h mre=%b pc=%b exp 080/0/0", sel, mre, pc_en); end
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk); mem_ack = (i == 3); #1;
            if (mre === 1'b1) mre_cycles++;
            checks++; if ({we, pc_en, mwe} !== 3'b000) begin errors++; $display("FAIL load_mem_strobes cyc=%0d got=%b exp=000", i, {we, pc_en, mwe}); end
        end
        checks++; if (mre_cycles !== 3) begin errors++; $display("FAIL load_mre_cycles got=%0d exp=3", mre_cycles); end
        @(negedge clk); mem_ack = 1'b0; #1;
        checks++; if ({we, pc_en, mre} !== 3'b110) begin errors++; $display("FAIL load_wb we_pc_mre=%b exp=110", {we, pc_en, mre}); end
        @(negedge clk); #1;
        checks++; if (instr_ready !== 1'b1 || {we, pc_en} !== 2'b00) begin errors++; $display("FAIL load_fetch ready=%b we_pc=%b exp 1/00", instr_ready, {we, pc_en}); end
    endtask

    task automatic test_store_fast();
        @(negedge clk); instr_valid = 1'b1; opcode = 4'b1000;
        @(negedge clk); instr_valid = 1'b0; #1;
        checks++; if ({mwe, pc_en} !== 2'b00) begin errors++; $display("FAIL store_exec mwe_pc=%b exp=00", {mwe, pc_en}); end
        @(negedge clk); mem_ack = 1'b1; #1;
        checks++; if ({mwe, pc_en, we} !== 3'b110) begin errors++; $display("FAIL store_ack mwe_pc_we=%b exp=110", {mwe, pc_en, we}); end
        @(negedge clk); mem_ack = 1'b0; #1;
        checks++; if (instr_ready !== 1'b1 || {mwe, pc_en} !== 2'b00) begin errors++; $display("FAIL store_fetch ready=%b mwe_pc=%b exp 1/00", instr_ready, {mwe, pc_en}); end
    endtask

    task automatic test_timeout();
        int bad = 0;
        @(negedge clk); instr_valid = 1'b1; opcode = 4'b1000;
        @(negedge clk); instr_valid = 1'b0; #1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk); err_clr = (i == 4); #1;
            if (mwe !== 1'b1 || pc_en !== 1'b0 || err !== 2'b00) bad++;
        end
        err_clr = 1'b0;
        checks++; if (bad != 0) begin errors++; $display("FAIL timeout_mem_window bad_cycles=%0d exp=0", bad); end
        @(negedge clk); mem_ack = 1'b1; #1;
        checks++; if (err !== 2'b10 || {mwe, pc_en, instr_ready} !== 3'b000) begin errors++; $display("FAIL timeout_error err=%b mwe_pc_rdy=%b exp 10/000", err, {mwe, pc_en, instr_ready}); end
        @(negedge clk); mem_ack = 1'b0; err_clr = 1'b1; #1;
        checks++; if (err !== 2'b10 || instr_ready !== 1'b0) begin errors++; $display("FAIL timeout_sticky err=%b ready=%b exp 10/0", err, instr_ready); end
        @(negedge clk); err_clr = 1'b0; #1;
        checks++; if (err !== 2'b00 || instr_ready !== 1'b1) begin errors++; $display("FAIL timeout_clear err=%b ready=%b exp 00/1", err, instr_ready); end
    endtask

    task automatic test_illegal();
        @(negedge clk); instr_valid = 1'b1; opcode = 4'b1101;
        @(negedge clk); #1;
        checks++; if ({we, pc_en} !== 2'b00 || sel !== 9'h0) begin errors++; $display("FAIL illegal_exec we_pc=%b sel=%h exp 00/000", {we, pc_en}, sel); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            checks++; if (err !== 2'b01 || {instr_ready, we, pc_en} !== 3'b000) begin errors++; $display("FAIL illegal_error cyc=%0d err=%b rdy_we_pc=%b exp 01/000", i, err, {instr_ready, we, pc_en}); end
        end
        instr_valid = 1'b0; err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0; #1;
        checks++; if (err !== 2'b00 || instr_ready !== 1'b1) begin errors++; $display("FAIL illegal_clear err=%b ready=%b exp 00/1", err, instr_ready); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk); instr_valid = 1'b1; opcode = 4'b0100;
        @(negedge clk); instr_valid = 1'b0; #1;
        checks++; if (sel !== 9'h0C0 || alu_op !== 3'b000) begin errors++; $display("FAIL rstmid_exec sel=%h alu=%b exp 0C0/000", sel, alu_op); end
        @(negedge clk); #1;
        checks++; if (we !== 1'b1) begin errors++; $display("FAIL rstmid_wb we=%b exp=1", we); end
        #1 rst_n = 1'b0; #1;
        checks++; if ({we, pc_en} !== 2'b00 || instr_ready !== 1'b1 || sel !== 9'h0) begin errors++; $display("FAIL rstmid_assert we_pc=%b ready=%b sel=%h exp 00/1/000", {we, pc_en}, instr_ready, sel); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); #1;
        checks++; if (instr_ready !== 1'b1 || {we, pc_en} !== 2'b00) begin errors++; $display("FAIL rstmid_release ready=%b we_pc=%b exp 1/00", instr_ready, {we, pc_en}); end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        @(negedge clk); instr_valid = 1'b1; opcode = 4'b1001; #1;
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL b2b_a ready=%b exp=1", instr_ready); end
        @(negedge clk); opcode = 4'b0010; #1; pulses += int'(pc_en);
        checks++; if (sel !== 9'h101 || alu_op !== 3'b001 || pc_en !== 1'b1 || instr_ready !== 1'b0) begin errors++; $display("FAIL b2b_exec1 sel=%h alu=%b pc=%b rdy=%b exp 101/001/1/0", sel, alu_op, pc_en, instr_ready); end
        @(negedge clk); #1; pulses += int'(pc_en);
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL b2b_fetch2 ready=%b exp=1", instr_ready); end
        @(negedge clk); opcode = 4'b1111; #1; pulses += int'(pc_en);
        checks++; if (outld !== 1'b1 || pc_en !== 1'b1 || sel !== 9'h0) begin errors++; $display("FAIL b2b_exec2 outld=%b pc=%b sel=%h exp 1/1/000", outld, pc_en, sel); end
        @(negedge clk); #1; pulses += int'(pc_en);
        @(negedge clk); instr_valid = 1'b0; #1; pulses += int'(pc_en);
        checks++; if (sel !== 9'h004 || pc_en !== 1'b1 || outld !== 1'b0) begin errors++; $display("FAIL b2b_exec3 sel=%h pc=%b outld=%b exp 004/1/0", sel, pc_en, outld); end
        @(negedge clk); #1; pulses += int'(pc_en);
        checks++; if (pulses !== 3) begin errors++; $display("FAIL b2b_pc_pulses got=%0d exp=3", pulses); end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_decode_table();
        test_load();
        test_store_fast();
        test_timeout();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
